// File: rtl/result_writeback.sv
// result_writeback: drains the systolic-array result stream through a skid FIFO into linear memory writes.
module result_writeback #(
  parameter int DATA_W     = 16,
  parameter int O_ROWS     = 512,
  parameter int O_COLS     = 32,
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              err_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic              mem_wr_ready
);
  localparam int N  = O_ROWS * O_COLS;
  localparam int CW = $clog2(N + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, RECV, DRAIN} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] fifo [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0] count;
  logic [CW-1:0] rx_cnt, wr_cnt;
  logic [ADDR_W-1:0] base_reg;
  logic empty, full, accept, pop, go, tail, fin;
  assign empty       = count == '0;
  assign full        = count == (PW+1)'(FIFO_DEPTH);
  // in_ready depends only on state and occupancy, never on the write side
  assign in_ready    = state == RECV && !full;
  assign accept      = in_valid && in_ready;
  assign mem_wr_en   = !empty && state != IDLE;
  assign pop         = mem_wr_en && mem_wr_ready;
  assign mem_wr_data = mem_wr_en ? fifo[rd_ptr] : '0;
  assign mem_wr_addr = base_reg + ADDR_W'(wr_cnt);
  assign go          = state == IDLE && start;
  assign tail        = rx_cnt == CW'(N - 1);
  assign fin         = wr_cnt == rx_cnt && empty;
  assign busy        = state != IDLE;
  assign done        = state == DRAIN && fin;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? RECV : IDLE;
      RECV:    state_nx = accept && (in_last || tail) ? DRAIN : RECV;
      DRAIN:   state_nx = fin ? IDLE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      rx_cnt   <= '0;
      wr_cnt   <= '0;
      base_reg <= '0;
      err_len  <= 1'b0;
    end else begin
      state <= state_nx;
      if (go) begin
        base_reg <= base_addr;
        rx_cnt   <= '0;
        wr_cnt   <= '0;
        err_len  <= 1'b0;
      end
      if (accept) begin
        wr_ptr <= wr_ptr + PW'(1);
        rx_cnt <= rx_cnt + CW'(1);
        if (in_last != tail) err_len <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        wr_cnt <= wr_cnt + CW'(1);
      end
      count <= accept && !pop ? count + (PW+1)'(1) : !accept && pop ? count - (PW+1)'(1) : count;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) fifo[wr_ptr] <= in_data;
  end
endmodule
